// File: rtl/reg_bus_splitter.sv
// One-to-N register bus fan-out: routes each upstream request to the slave region picked by address.
// Optional REG_BUS_TIMEOUT_EN macro adds a WAIT-state timeout that answers with an error.
//
// state  | meaning
// IDLE   | waiting for bus_req, decode address
// REQ    | one-cycle request pulse to the selected slave
// WAIT   | holding for the selected slave's ready
// RESP   | one-cycle upstream response pulse
module reg_bus_splitter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int REGION_BITS    = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             bus_req,
  input  logic                             bus_req_is_wr,
  input  logic [ADDR_WIDTH-1:0]            bus_addr,
  input  logic [DATA_WIDTH-1:0]            bus_wr_data,
  input  logic [DATA_WIDTH/8-1:0]          bus_wr_strobe,
  output logic                             bus_ready,
  output logic                             bus_err,
  output logic [DATA_WIDTH-1:0]            bus_rd_data,
  output logic                             busy,
  output logic [NUM_SLAVES-1:0]            s_bus_req,
  output logic                             s_bus_req_is_wr,
  output logic [REGION_BITS-1:0]           s_bus_addr,
  output logic [DATA_WIDTH-1:0]            s_bus_wr_data,
  output logic [DATA_WIDTH/8-1:0]          s_bus_wr_strobe,
  input  logic [NUM_SLAVES-1:0]            s_bus_ready,
  input  logic [NUM_SLAVES-1:0]            s_bus_err,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_bus_rd_data
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [NUM_SLAVES-1:0] SEL_ONE = NUM_SLAVES'(1);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("reg_bus_splitter: NUM_SLAVES must be 1..16 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t                  state;
  logic [SEL_W-1:0]        slot_q;
  logic [SEL_W-1:0]        req_slot;
  logic                    dec_err;
  logic                    sel_ready;
  logic                    sel_err;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [DATA_WIDTH-1:0]   resp_data;

`ifdef REG_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  // Down-counter: reaching zero marks the last WAIT cycle before timeout.
  logic [CNT_W-1:0] tmo_cnt;
`endif

  always_comb begin
    req_slot = bus_addr[REGION_BITS +: SEL_W];
    dec_err  = (int'(req_slot) >= NUM_SLAVES) ||
               ((bus_addr >> (REGION_BITS + SEL_W)) != '0);
  end

  always_comb begin
    sel_ready = s_bus_ready[slot_q];
    sel_err   = s_bus_err[slot_q];
    sel_data  = s_bus_rd_data[slot_q*DATA_WIDTH +: DATA_WIDTH];
    resp_data = s_bus_req_is_wr ? '0 : sel_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= S_IDLE;
      slot_q          <= '0;
      bus_ready       <= 1'b0;
      bus_err         <= 1'b0;
      bus_rd_data     <= '0;
      busy            <= 1'b0;
      s_bus_req       <= '0;
      s_bus_req_is_wr <= 1'b0;
      s_bus_addr      <= '0;
      s_bus_wr_data   <= '0;
      s_bus_wr_strobe <= '0;
`ifdef REG_BUS_TIMEOUT_EN
      tmo_cnt         <= '0;
`endif
    end else begin
      bus_ready <= 1'b0;
      s_bus_req <= '0;
      case (state)
        S_IDLE: begin
          if (bus_req) begin
            s_bus_req_is_wr <= bus_req_is_wr;
            s_bus_addr      <= bus_addr[REGION_BITS-1:0];
            s_bus_wr_data   <= bus_wr_data;
            s_bus_wr_strobe <= bus_wr_strobe;
            slot_q          <= req_slot;
            busy            <= 1'b1;
            if (dec_err) begin
              bus_ready   <= 1'b1;
              bus_err     <= 1'b1;
              bus_rd_data <= '0;
              state       <= S_RESP;
            end else begin
              s_bus_req <= SEL_ONE << req_slot;
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
`ifdef REG_BUS_TIMEOUT_EN
          tmo_cnt <= CNT_LOAD;
`endif
          if (sel_ready) begin
            bus_ready   <= 1'b1;
            bus_err     <= sel_err;
            bus_rd_data <= resp_data;
            state       <= S_RESP;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A slave answer in the final allowed cycle beats the timeout.
          if (sel_ready) begin
            bus_ready   <= 1'b1;
            bus_err     <= sel_err;
            bus_rd_data <= resp_data;
            state       <= S_RESP;
          end
`ifdef REG_BUS_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            bus_ready   <= 1'b1;
            bus_err     <= 1'b1;
            bus_rd_data <= '0;
            state       <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`else
          else begin
            state <= S_WAIT;
          end
`endif
        end
        S_RESP: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
